// File: rtl/spawn_scheduler_pkg.sv
// Shared types and constants for the obstacle/coin spawn scheduler.
// Slot order: 0 tree-right, 1 tree-left, 2 rock-right, 3 rock-left.
package spawn_pkg;

    localparam int N_SLOTS       = 4;
    localparam int SLOT_W        = 2;
    localparam int LANE_COUNT    = 3;
    localparam int RND_W         = 20;

    localparam int SLOT_TREE_R   = 0;
    localparam int SLOT_TREE_L   = 1;
    localparam int SLOT_ROCK_R   = 2;
    localparam int SLOT_ROCK_L   = 3;

    // Lanes covered by each slot's obstacle; slot 0 in bits [2:0].
    localparam logic [N_SLOTS*LANE_COUNT-1:0] SLOT_LANES = 12'b001_100_011_110;

    localparam int COOLDOWN_INIT = 48;
    localparam int COOLDOWN_MIN  = 12;
    localparam int RAMP_PERIOD   = 256;
    localparam int ACK_TIMEOUT   = 2;
    localparam int TMO_W         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOL,
        S_PICK,
        S_ARM,
        S_WAIT_ACK,
        S_OCCUPIED
    } sched_state_t;

    // Next slot index, wrapping at N_SLOTS.
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        if (32'(s) == 32'(N_SLOTS - 1)) begin
            return '0;
        end
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/spawn_scheduler_if.sv
// Game-side bundle of the spawn scheduler: random word and spawner status
// in, spawn pulses and difficulty status out.
interface spawn_scheduler_if;
    import spawn_pkg::*;

    logic                  run;
    logic [RND_W-1:0]      rnd;
    logic [N_SLOTS-1:0]    obst_active;
    logic [LANE_COUNT-1:0] coin_active;
    logic [N_SLOTS-1:0]    obst_spawn;
    logic [LANE_COUNT-1:0] coin_spawn;
    logic [3:0]            level;
    logic                  busy;

    // Game logic / spawner bank side.
    modport master (
        output run, rnd, obst_active, coin_active,
        input  obst_spawn, coin_spawn, level, busy
    );

    // Scheduler side.
    modport slave (
        input  run, rnd, obst_active, coin_active,
        output obst_spawn, coin_spawn, level, busy
    );

endinterface

// File: rtl/spawn_scheduler_difficulty_ramp.sv
// Difficulty ramp: counts frames of play, raises the level once per
// RAMP_PERIOD frames (saturating at 15) and derives the obstacle cooldown.
// Build option: SPAWN_SCHED_RAMP_EN enables the ramp; without it the level
// stays 0 and the cooldown is fixed at COOLDOWN_INIT.
module difficulty_ramp
    import spawn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    output logic [3:0] level_o,
    output logic [7:0] cooldown_o
);

`ifdef SPAWN_SCHED_RAMP_EN
    localparam int RAMP_W = $clog2(RAMP_PERIOD);

    logic [RAMP_W-1:0] ramp_q;
    logic [3:0]        level_q;
    logic [7:0]        ramp_step;

    // Frame counter and level; both restart whenever play stops.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_q  <= '0;
            level_q <= '0;
        end else if (!run_i) begin
            ramp_q  <= '0;
            level_q <= '0;
        end else if (ramp_q == RAMP_W'(RAMP_PERIOD - 1)) begin
            ramp_q <= '0;
            if (level_q != 4'hF) begin
                level_q <= level_q + 4'd1;
            end
        end else begin
            ramp_q <= ramp_q + 1'b1;
        end
    end

    // Cooldown shrinks by 4 frames per level and clamps at the floor.
    always_comb begin
        ramp_step = {2'b00, level_q, 2'b00};
        if (ramp_step >= 8'(COOLDOWN_INIT - COOLDOWN_MIN)) begin
            cooldown_o = 8'(COOLDOWN_MIN);
        end else begin
            cooldown_o = 8'(COOLDOWN_INIT) - ramp_step;
        end
    end

    assign level_o = level_q;
`else
    logic unused_ramp;

    assign level_o     = '0;
    assign cooldown_o  = 8'(COOLDOWN_INIT);
    assign unused_ramp = ^{clk, rst, run_i};
`endif

endmodule

// File: rtl/spawn_scheduler.sv
// Frame-rate spawn scheduler: keeps at most one obstacle in flight, spaces
// obstacles by a cooldown, avoids repeating the same slot and gates coin
// spawns away from lanes blocked by obstacles. All outputs are registered.
module spawn_scheduler
    import spawn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    spawn_scheduler_if.slave   sched
);

    sched_state_t          state_q;
    logic [SLOT_W-1:0]     sel_q;
    logic [SLOT_W-1:0]     last_sel_q;
    logic [7:0]            cool_cnt_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [N_SLOTS-1:0]    obst_spawn_q;
    logic [LANE_COUNT-1:0] coin_spawn_q;

    logic [SLOT_W-1:0]     sel_d;
    logic [LANE_COUNT-1:0] blk_d;
    logic [LANE_COUNT-1:0] coin_d;
    logic [3:0]            level;
    logic [7:0]            cooldown;
    logic                  unused_rnd;

    difficulty_ramp u_ramp (
        .clk        (clk),
        .rst        (rst),
        .run_i      (sched.run),
        .level_o    (level),
        .cooldown_o (cooldown)
    );

    // Slot choice: random slot, bumped to the next one on an unlucky repeat.
    always_comb begin
        sel_d = SLOT_W'(32'(sched.rnd[1:0]) % 32'(N_SLOTS));
        if (sel_d == last_sel_q && !sched.rnd[10]) begin
            sel_d = next_slot(sel_d);
        end
    end

    // Lanes blocked by live obstacles or by the one being launched, and the coin requests they allow.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        blk_d  = '0;
        coin_d = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (sched.obst_active[s] ||
                ((state_q == S_ARM || state_q == S_WAIT_ACK) && 32'(sel_q) == 32'(s))) begin
                blk_d = blk_d | SLOT_LANES[s*LANE_COUNT +: LANE_COUNT];
            end
        end
        for (int l = 0; l < LANE_COUNT; l++) begin
            coin_d[l] = (sched.rnd[10 + 3*l +: 3] == 3'b111) && !blk_d[l] && !sched.coin_active[l];
        end
    end

    // Scheduler FSM with its registered spawn pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            last_sel_q   <= '0;
            cool_cnt_q   <= '0;
            tmo_q        <= '0;
            obst_spawn_q <= '0;
            coin_spawn_q <= '0;
        end else if (!sched.run) begin
            // Leaving play wins over any pending acknowledge or timeout.
            state_q      <= S_IDLE;
            last_sel_q   <= '0;
            tmo_q        <= '0;
            obst_spawn_q <= '0;
            coin_spawn_q <= '0;
        end else begin
            obst_spawn_q <= '0;
            coin_spawn_q <= (state_q != S_IDLE) ? coin_d : '0;
            case (state_q)
                S_IDLE: begin
                    cool_cnt_q <= cooldown;
                    state_q    <= S_COOL;
                end
                S_COOL: begin
                    if (cool_cnt_q <= 8'd1) begin
                        state_q <= (|sched.obst_active) ? S_OCCUPIED : S_PICK;
                    end else begin
                        cool_cnt_q <= cool_cnt_q - 8'd1;
                    end
                end
                S_PICK: begin
                    sel_q   <= sel_d;
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    obst_spawn_q <= N_SLOTS'(1) << sel_q;
                    last_sel_q   <= sel_q;
                    tmo_q        <= '0;
                    state_q      <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Acknowledge is tested first so it wins over a same-frame timeout.
                    if (sched.obst_active[sel_q]) begin
                        state_q <= S_OCCUPIED;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        cool_cnt_q <= cooldown;
                        state_q    <= S_COOL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_OCCUPIED: begin
                    if (!(|sched.obst_active)) begin
                        cool_cnt_q <= cooldown;
                        state_q    <= S_COOL;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sched.obst_spawn = obst_spawn_q;
    assign sched.coin_spawn = coin_spawn_q;
    assign sched.level      = level;
    assign sched.busy       = (state_q != S_IDLE);
    assign unused_rnd       = ^{sched.rnd[19], sched.rnd[9:2]};

endmodule

// File: tb/tb_spawn_scheduler.sv
// Self-checking bench for spawn_scheduler. Obstacle pulses are scored
// against a queue of expected (frame, mask) entries; the other outputs are
// compared inline in each scenario task.
module tb_spawn_scheduler;
    import spawn_pkg::*;

    typedef struct {
        int                 frame;
        logic [N_SLOTS-1:0] mask;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int frame  = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    pulse_t exp_q[$];

    spawn_scheduler_if sif ();

    spawn_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sif)
    );

    always #5 clk = ~clk;

    // One frame: wait for the edge, sample 1 time unit later and score obst_spawn.
    task automatic tick(input int n = 1);
        logic [N_SLOTS-1:0] want;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            frame++;
            #1;
            want = '0;
            if (exp_q.size() != 0 && exp_q[0].frame == frame) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            checks++;
            if (sif.obst_spawn !== want) begin
                errors++;
                $display("FAIL obst_spawn frame %0d: got %b expected %b", frame, sif.obst_spawn, want);
            end
            if (sif.obst_spawn != '0) begin
                prev_pulse = last_pulse;
                last_pulse = frame;
            end
        end
    endtask

    task automatic wait_frame(input int f);
        while (frame < f) tick();
    endtask

    task automatic expect_pulse(input int f, input logic [N_SLOTS-1:0] m);
        exp_q.push_back('{frame: f, mask: m});
    endtask

    task automatic stop_run();
        sif.run = 1'b0;
        tick(2);
        sif.obst_active = '0;
        sif.coin_active = '0;
        sif.rnd         = '0;
    endtask

    task automatic check_pending(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses never seen (next at frame %0d)", name, exp_q.size(), exp_q[0].frame);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        sif.run = 1'b0; sif.rnd = '0; sif.obst_active = '0; sif.coin_active = '0;
        tick(2);
        checks++;
        if ({sif.busy, sif.level, sif.coin_spawn} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b level=%0d coin=%b expected all 0", sif.busy, sif.level, sif.coin_spawn);
        end
        rst = 1'b0;
        // Enter COOL with every coin pattern hit and no obstacle: all lanes free.
        sif.rnd = 20'h7FC00;
        sif.run = 1'b1;
        tick(5);
        checks++;
        if (sif.busy !== 1'b1 || sif.coin_spawn !== 3'b111) begin
            errors++;
            $display("FAIL cool_state: got busy=%b coin=%b expected busy=1 coin=111", sif.busy, sif.coin_spawn);
        end
        // Asynchronous reset in the middle of the frame.
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sif.busy, sif.level, sif.coin_spawn, sif.obst_spawn} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: got busy=%b level=%0d coin=%b obst=%b expected all 0", sif.busy, sif.level, sif.coin_spawn, sif.obst_spawn);
        end
        tick();
        checks++;
        if ({sif.busy, sif.level, sif.coin_spawn} !== 8'h00) begin
            errors++;
            $display("FAIL reset_next_frame: got busy=%b level=%0d coin=%b expected all 0", sif.busy, sif.level, sif.coin_spawn);
        end
        sif.run = 1'b0;
        sif.rnd = '0;
        rst = 1'b0;
        tick(2);
        checks++;
        if (sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b expected 0", sif.busy);
        end
    endtask

    // Nobody acknowledges: pulse at k+50, timeout reload at k+52, next pulse at k+102.
    task automatic test_timeout();
        int k;
        sif.rnd = 20'h00402;
        sif.run = 1'b1;
        k = frame + 1;
        expect_pulse(k + 50, 4'b0100);
        expect_pulse(k + 102, 4'b0100);
        wait_frame(k + 51);
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_ack_busy: got %b expected 1", sif.busy);
        end
        wait_frame(k + 105);
        check_pending("timeout_pulses");
        stop_run();
    endtask

    // Ack lands with the timeout frame (ack wins), coins gated while occupied, reload on drop.
    task automatic test_occupied();
        int k;
        sif.rnd = 20'h00400;
        sif.run = 1'b1;
        k = frame + 1;
        expect_pulse(k + 50, 4'b0001);
        wait_frame(k + 51);
        sif.obst_active = 4'b0001;
        wait_frame(k + 53);
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL occupied_busy: got %b expected 1", sif.busy);
        end
        sif.rnd = 20'h7FC00;
        tick();
        checks++;
        if (sif.coin_spawn !== 3'b001) begin
            errors++;
            $display("FAIL coin_slot0: got %b expected 001", sif.coin_spawn);
        end
        sif.coin_active = 3'b001;
        tick();
        checks++;
        if (sif.coin_spawn !== 3'b000) begin
            errors++;
            $display("FAIL coin_lane_busy: got %b expected 000", sif.coin_spawn);
        end
        sif.coin_active = 3'b000;
        sif.obst_active = 4'b1000;
        tick();
        checks++;
        if (sif.coin_spawn !== 3'b110) begin
            errors++;
            $display("FAIL coin_slot3: got %b expected 110", sif.coin_spawn);
        end
        sif.obst_active = 4'b0001;
        sif.rnd = 20'h00400;
        wait_frame(k + 81);
        sif.obst_active = 4'b0000;
        expect_pulse(k + 132, 4'b0001);
        wait_frame(k + 135);
        check_pending("occupied_pulses");
        stop_run();
    endtask

    // last_sel=3 and the same draw with rnd[10]=0 must bump to slot 0.
    task automatic test_repeat();
        int k;
        sif.rnd = 20'h00403;
        sif.run = 1'b1;
        k = frame + 1;
        expect_pulse(k + 50, 4'b1000);
        expect_pulse(k + 102, 4'b0001);
        wait_frame(k + 51);
        sif.rnd = 20'h00003;
        wait_frame(k + 105);
        check_pending("repeat_pulses");
        stop_run();
    endtask

    // Acknowledge and run drop in the same frame: run wins, state IDLE.
    task automatic test_run_wins();
        int k;
        sif.rnd = 20'h00401;
        sif.run = 1'b1;
        k = frame + 1;
        expect_pulse(k + 50, 4'b0010);
        wait_frame(k + 50);
        sif.obst_active = 4'b0010;
        sif.run = 1'b0;
        tick();
        checks++;
        if (sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL run_wins_busy: got %b expected 0", sif.busy);
        end
        check_pending("run_wins_pulse");
        stop_run();
    endtask

    // Long run: expected pulses derived from the level in force at each cooldown load.
    task automatic test_ramp();
        int k, r, p, lvl, cd, horizon, exp_lvl, exp_cd;
        sif.rnd = 20'h00400;
        sif.run = 1'b1;
        k = frame + 1;
        horizon = k + 256 * 9 + 60;
        r = k;
        for (int i = 0; i < 400; i++) begin
`ifdef SPAWN_SCHED_RAMP_EN
            lvl = (r - k) / 256;
            if (lvl > 15) lvl = 15;
`else
            lvl = 0;
`endif
            cd = 48 - 4 * lvl;
            if (cd < 12) cd = 12;
            p = r + cd + 2;
            if (p > horizon) break;
            expect_pulse(p, 4'b0001);
            r = p + 2;
        end
`ifdef SPAWN_SCHED_RAMP_EN
        exp_lvl = 9;
        exp_cd  = 12;
`else
        exp_lvl = 0;
        exp_cd  = 48;
`endif
        wait_frame(k + 256 * 9 - 1);
        checks++;
        if (sif.level !== 4'(exp_lvl)) begin
            errors++;
            $display("FAIL ramp_level: got %0d expected %0d", sif.level, exp_lvl);
        end
        wait_frame(horizon);
        check_pending("ramp_pulses");
        checks++;
        if (last_pulse - prev_pulse !== exp_cd + 4) begin
            errors++;
            $display("FAIL ramp_cooldown: got period %0d expected %0d", last_pulse - prev_pulse, exp_cd + 4);
        end
        stop_run();
        checks++;
        if (sif.level !== 4'd0) begin
            errors++;
            $display("FAIL level_cleared: got %0d expected 0", sif.level);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_occupied();
        test_repeat();
        test_run_wins();
        test_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by frame %0d", frame);
        $fatal(1, "watchdog expired");
    end

endmodule
